// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the
// execute (requester 0) and load-unit (requester 1) writeback paths.
module regfile_wb_arbiter #(
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned DATA_W     = 32,
    parameter bit          PRIO_RESET = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_src,
    output logic              conflict
);

    logic              r_last_grant;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_wr_src;
    logic              r_conflict;

    logic              w_grant0;
    logic              w_grant1;
    logic              w_any;
    logic              w_contend;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;

    // Grant decode: a contended cycle goes to the requester not granted last.
    always_comb begin
        w_grant0  = 1'b0;
        w_grant1  = 1'b0;
        w_contend = req0_valid & req1_valid & ~hold;
        if (!rst && !hold) begin
            w_grant0 = req0_valid & (~req1_valid | r_last_grant);
            w_grant1 = req1_valid & (~req0_valid | ~r_last_grant);
        end
        w_any  = w_grant0 | w_grant1;
        w_addr = w_grant1 ? req1_addr : req0_addr;
        w_data = w_grant1 ? req1_data : req0_data;
    end

    // Write-port registers; writes to x0 load addr/data but keep wr_en low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= ~PRIO_RESET;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_wr_src     <= 1'b0;
            r_conflict   <= 1'b0;
        end else begin
            r_conflict <= w_contend;
            r_wr_en    <= w_any && (w_addr != '0);
            if (w_any) begin
                r_last_grant <= w_grant1;
                r_wr_addr    <= w_addr;
                r_wr_data    <= w_data;
                r_wr_src     <= w_grant1;
            end
        end
    end

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign wr_src     = r_wr_src;
    assign conflict   = r_conflict;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter; d0 uses PRIO_RESET=0, d1 PRIO_RESET=1.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst, hold;
    logic        v0, v1;
    logic [4:0]  a0, a1;
    logic [31:0] dat0, dat1;

    logic        d0_rdy0, d0_rdy1, d0_en, d0_src, d0_cf;
    logic [4:0]  d0_addr;
    logic [31:0] d0_data;
    logic        d1_rdy0, d1_rdy1, d1_en, d1_src, d1_cf;
    logic [4:0]  d1_addr;
    logic [31:0] d1_data;

    logic [31:0] rf1 [0:31];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.ADDR_W(5), .DATA_W(32), .PRIO_RESET(1'b0)) d0 (
        .clk(clk), .rst(rst), .hold(hold),
        .req0_valid(v0), .req0_addr(a0), .req0_data(dat0), .req0_ready(d0_rdy0),
        .req1_valid(v1), .req1_addr(a1), .req1_data(dat1), .req1_ready(d0_rdy1),
        .wr_en(d0_en), .wr_addr(d0_addr), .wr_data(d0_data), .wr_src(d0_src),
        .conflict(d0_cf));

    regfile_wb_arbiter #(.ADDR_W(5), .DATA_W(32), .PRIO_RESET(1'b1)) d1 (
        .clk(clk), .rst(rst), .hold(hold),
        .req0_valid(v0), .req0_addr(a0), .req0_data(dat0), .req0_ready(d1_rdy0),
        .req1_valid(v1), .req1_addr(a1), .req1_data(dat1), .req1_ready(d1_rdy1),
        .wr_en(d1_en), .wr_addr(d1_addr), .wr_data(d1_data), .wr_src(d1_src),
        .conflict(d1_cf));

    // Register-file model behind d1's write port.
    always @(posedge clk) begin
        if (d1_en) rf1[d1_addr] <= d1_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; hold = 1'b0; v0 = 1'b1; v1 = 1'b1;
        a0 = 5'd5; a1 = 5'd7; dat0 = 32'h1; dat1 = 32'h2;
        tick(); tick();
        @(negedge clk);
        checks++; if (d0_rdy0 !== 1'b0 || d0_rdy1 !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b%b exp=00", d0_rdy0, d0_rdy1); end
        checks++; if (d0_en !== 1'b0 || d0_addr !== 5'd0 || d0_data !== 32'd0 || d0_src !== 1'b0 || d0_cf !== 1'b0) begin errors++; $display("FAIL rst_outputs got en=%b addr=%0d data=%h src=%b cf=%b exp all 0", d0_en, d0_addr, d0_data, d0_src, d0_cf); end
        rst = 1'b0; v0 = 1'b0; v1 = 1'b0;
        tick();
    endtask

    task automatic test_contend();
        v0 = 1'b1; a0 = 5'd5; dat0 = 32'hDEADBEEF;
        v1 = 1'b1; a1 = 5'd7; dat1 = 32'h12345678;
        @(negedge clk);
        checks++; if (d0_rdy0 !== 1'b1 || d0_rdy1 !== 1'b0) begin errors++; $display("FAIL c1_ready got=%b%b exp=10", d0_rdy0, d0_rdy1); end
        tick(); v0 = 1'b0;
        @(negedge clk);
        checks++; if (d0_en !== 1'b1 || d0_addr !== 5'd5 || d0_data !== 32'hDEADBEEF || d0_src !== 1'b0 || d0_cf !== 1'b1) begin errors++; $display("FAIL c1_write got en=%b addr=%0d data=%h src=%b cf=%b exp 1/5/deadbeef/0/1", d0_en, d0_addr, d0_data, d0_src, d0_cf); end
        checks++; if (d0_rdy1 !== 1'b1) begin errors++; $display("FAIL c2_ready1 got=%b exp=1", d0_rdy1); end
        tick(); v1 = 1'b0;
        @(negedge clk);
        checks++; if (d0_en !== 1'b1 || d0_addr !== 5'd7 || d0_data !== 32'h12345678 || d0_src !== 1'b1 || d0_cf !== 1'b0) begin errors++; $display("FAIL c2_write got en=%b addr=%0d data=%h src=%b cf=%b exp 1/7/12345678/1/0", d0_en, d0_addr, d0_data, d0_src, d0_cf); end
        tick();
    endtask

    task automatic test_alternate();
        logic exp_g;
        v0 = 1'b1; v1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp_g = 1'(i % 2);
            @(negedge clk);
            checks++; if (d0_rdy0 !== ~exp_g || d0_rdy1 !== exp_g) begin errors++; $display("FAIL alt_grant[%0d] got=%b%b exp=%b%b", i, d0_rdy0, d0_rdy1, ~exp_g, exp_g); end
            if (i > 0) begin
                checks++; if (d0_en !== 1'b1 || d0_src !== ~exp_g || d0_cf !== 1'b1) begin errors++; $display("FAIL alt_write[%0d] got en=%b src=%b cf=%b exp 1/%b/1", i, d0_en, d0_src, d0_cf, ~exp_g); end
            end
            tick();
        end
        v0 = 1'b0; v1 = 1'b0;
        @(negedge clk);
        checks++; if (d0_en !== 1'b1 || d0_src !== 1'b1 || d0_addr !== 5'd7) begin errors++; $display("FAIL alt_last got en=%b src=%b addr=%0d exp 1/1/7", d0_en, d0_src, d0_addr); end
        tick();
    endtask

    task automatic test_x0();
        v0 = 1'b1; a0 = 5'd3; dat0 = 32'h33;
        tick(); v0 = 1'b0;
        v1 = 1'b1; a1 = 5'd0; dat1 = 32'hFFFFFFFF;
        @(negedge clk);
        checks++; if (d0_rdy1 !== 1'b1 || d0_rdy0 !== 1'b0) begin errors++; $display("FAIL x0_ready got=%b%b exp=01", d0_rdy0, d0_rdy1); end
        tick();
        v0 = 1'b1; a0 = 5'd5; dat0 = 32'h55; a1 = 5'd7; dat1 = 32'h77;
        @(negedge clk);
        checks++; if (d0_en !== 1'b0 || d0_addr !== 5'd0 || d0_data !== 32'hFFFFFFFF || d0_src !== 1'b1) begin errors++; $display("FAIL x0_write got en=%b addr=%0d data=%h src=%b exp 0/0/ffffffff/1", d0_en, d0_addr, d0_data, d0_src); end
        checks++; if (d0_rdy0 !== 1'b1 || d0_rdy1 !== 1'b0) begin errors++; $display("FAIL x0_next_grant got=%b%b exp=10", d0_rdy0, d0_rdy1); end
        tick(); v0 = 1'b0; v1 = 1'b0;
        @(negedge clk);
        checks++; if (d0_en !== 1'b1 || d0_addr !== 5'd5 || d0_src !== 1'b0) begin errors++; $display("FAIL x0_after got en=%b addr=%0d src=%b exp 1/5/0", d0_en, d0_addr, d0_src); end
        tick();
    endtask

    task automatic test_hold();
        hold = 1'b1; v0 = 1'b1; v1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (d0_rdy0 !== 1'b0 || d0_rdy1 !== 1'b0 || d0_en !== 1'b0 || d0_cf !== 1'b0) begin errors++; $display("FAIL hold[%0d] got rdy=%b%b en=%b cf=%b exp 00/0/0", i, d0_rdy0, d0_rdy1, d0_en, d0_cf); end
            tick();
        end
        hold = 1'b0;
        @(negedge clk);
        checks++; if (d0_rdy0 !== 1'b0 || d0_rdy1 !== 1'b1 || d0_en !== 1'b0 || d0_cf !== 1'b0) begin errors++; $display("FAIL hold_release got rdy=%b%b en=%b cf=%b exp 01/0/0", d0_rdy0, d0_rdy1, d0_en, d0_cf); end
        tick(); v0 = 1'b0; v1 = 1'b0;
        @(negedge clk);
        checks++; if (d0_en !== 1'b1 || d0_src !== 1'b1 || d0_addr !== 5'd7 || d0_cf !== 1'b1) begin errors++; $display("FAIL hold_write got en=%b src=%b addr=%0d cf=%b exp 1/1/7/1", d0_en, d0_src, d0_addr, d0_cf); end
        tick();
    endtask

    task automatic test_same_dest();
        rst = 1'b1; tick(); rst = 1'b0;
        v0 = 1'b1; a0 = 5'd9; dat0 = 32'hA;
        v1 = 1'b1; a1 = 5'd9; dat1 = 32'hB;
        @(negedge clk);
        checks++; if (d1_rdy1 !== 1'b1 || d1_rdy0 !== 1'b0) begin errors++; $display("FAIL same_first_grant got=%b%b exp=01", d1_rdy0, d1_rdy1); end
        tick(); v1 = 1'b0;
        @(negedge clk);
        checks++; if (d1_en !== 1'b1 || d1_addr !== 5'd9 || d1_data !== 32'hB || d1_src !== 1'b1) begin errors++; $display("FAIL same_write_b got en=%b addr=%0d data=%h src=%b exp 1/9/b/1", d1_en, d1_addr, d1_data, d1_src); end
        checks++; if (d1_rdy0 !== 1'b1) begin errors++; $display("FAIL same_second_grant got=%b exp=1", d1_rdy0); end
        tick(); v0 = 1'b0;
        @(negedge clk);
        checks++; if (d1_en !== 1'b1 || d1_data !== 32'hA || d1_src !== 1'b0) begin errors++; $display("FAIL same_write_a got en=%b data=%h src=%b exp 1/a/0", d1_en, d1_data, d1_src); end
        tick();
        @(negedge clk);
        checks++; if (rf1[9] !== 32'hA) begin errors++; $display("FAIL same_rf_final got=%h exp=a", rf1[9]); end
        tick();
    endtask

    task automatic test_mid_reset();
        v0 = 1'b1; a0 = 5'd5; dat0 = 32'h55;
        v1 = 1'b1; a1 = 5'd7; dat1 = 32'h77;
        tick(); tick();
        rst = 1'b1;
        @(negedge clk);
        checks++; if (d0_rdy0 !== 1'b0 || d0_rdy1 !== 1'b0 || d1_rdy0 !== 1'b0 || d1_rdy1 !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got d0=%b%b d1=%b%b exp 00/00", d0_rdy0, d0_rdy1, d1_rdy0, d1_rdy1); end
        checks++; if (d0_en !== 1'b1) begin errors++; $display("FAIL mid_rst_pre_en got=%b exp=1", d0_en); end
        tick(); rst = 1'b0;
        @(negedge clk);
        checks++; if (d0_en !== 1'b0 || d0_addr !== 5'd0 || d0_data !== 32'd0 || d0_src !== 1'b0 || d0_cf !== 1'b0) begin errors++; $display("FAIL mid_rst_d0_out got en=%b addr=%0d data=%h src=%b cf=%b exp all 0", d0_en, d0_addr, d0_data, d0_src, d0_cf); end
        checks++; if (d1_en !== 1'b0 || d1_addr !== 5'd0 || d1_data !== 32'd0 || d1_src !== 1'b0 || d1_cf !== 1'b0) begin errors++; $display("FAIL mid_rst_d1_out got en=%b addr=%0d data=%h src=%b cf=%b exp all 0", d1_en, d1_addr, d1_data, d1_src, d1_cf); end
        checks++; if (d0_rdy0 !== 1'b1 || d0_rdy1 !== 1'b0) begin errors++; $display("FAIL mid_rst_d0_grant got=%b%b exp=10", d0_rdy0, d0_rdy1); end
        checks++; if (d1_rdy0 !== 1'b0 || d1_rdy1 !== 1'b1) begin errors++; $display("FAIL mid_rst_d1_grant got=%b%b exp=01", d1_rdy0, d1_rdy1); end
        tick(); v0 = 1'b0; v1 = 1'b0;
        @(negedge clk);
        checks++; if (d0_en !== 1'b1 || d0_src !== 1'b0 || d0_addr !== 5'd5 || d0_cf !== 1'b1) begin errors++; $display("FAIL mid_rst_write got en=%b src=%b addr=%0d cf=%b exp 1/0/5/1", d0_en, d0_src, d0_addr, d0_cf); end
        tick();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf1[i] = 32'd0;
        test_reset();
        test_contend();
        test_alternate();
        test_x0();
        test_hold();
        test_same_dest();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (5-bit register address, 32-bit data) between two writeback requesters.
- Requester 0 is the execute/ALU writeback; requester 1 is the load-unit writeback.
- Grants at most one write per cycle using round-robin. The winning write is registered onto the write port one cycle after acceptance.
- Sits between the execute/memory stages and the register file, and drives the same address bus the address UVC monitors.

Parameters:
- ADDR_W, 5, register address width (32 architectural registers).
- DATA_W, 32, write data width.
- PRIO_RESET, 0, requester that wins the first contended cycle after reset (0 or 1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- hold  in  1  freeze arbitration (debug halt / pipeline stall).
- req0_valid  in  1  requester 0 has a write pending.
- req0_addr  in  ADDR_W  requester 0 destination register.
- req0_data  in  DATA_W  requester 0 write data.
- req0_ready  out  1  requester 0 write accepted this cycle.
- req1_valid  in  1  requester 1 has a write pending.
- req1_addr  in  ADDR_W  requester 1 destination register.
- req1_data  in  DATA_W  requester 1 write data.
- req1_ready  out  1  requester 1 write accepted this cycle.
- wr_en  out  1  register-file write enable (registered).
- wr_addr  out  ADDR_W  register-file write address (registered).
- wr_data  out  DATA_W  register-file write data (registered).
- wr_src  out  1  requester that produced the current write (registered).
- conflict  out  1  pulses high (registered) the cycle after both requesters were valid and hold was low.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Handshake:
  - A transfer occurs on a requester when valid=1 and ready=1 at a rising edge.
  - readyN is combinational from the valid inputs, hold and the RR pointer.
  - Requesters keep valid, addr and data stable until ready is seen.
- State: RR pointer last_grant (1 bit). Reset value is ~PRIO_RESET.
- Grant rules when hold=0:
  - Only req0_valid: grant 0.
  - Only req1_valid: grant 1.
  - Both valid: grant the requester != last_grant.
  - Neither valid: no grant.
- At most one ready is high per cycle; never both.
- last_grant updates to the granted index on every grant, contended or not.
- When hold=1: both ready=0, no grant, last_grant unchanged, and wr_en=0 on the next cycle.
- Latency: an accepted write at edge N appears on wr_en/wr_addr/wr_data/wr_src for exactly the cycle after edge N. No buffering; the outputs carry one write per cycle.
- Register x0:
  - A request with addr==0 is still granted and its ready still asserts.
  - last_grant still updates.
  - wr_en stays 0 for that write; wr_addr and wr_data are still loaded.
- No grant in a cycle: wr_en=0 next cycle; wr_addr, wr_data and wr_src hold their previous values.
- Same destination from both requesters in one cycle: no special handling. RR order serializes them, so the second-granted write lands last and wins in the register file.
- conflict: the registered value of (req0_valid & req1_valid & ~hold).
- Reset, including mid-operation:
  - Registered outputs wr_en=0, wr_addr=0, wr_data=0, wr_src=0, conflict=0.
  - last_grant = ~PRIO_RESET.
  - req0_ready=0 and req1_ready=0 while rst=1.
  - A write accepted on the edge where rst is sampled high is discarded.
- Widths: no arithmetic. Address and data pass through unmodified; ADDR_W and DATA_W only size the registers.

Test Plan:
- Reset with PRIO_RESET=0, then assert req0 (addr=5, data=0xDEADBEEF) and req1 (addr=7, data=0x12345678) on the same cycle:
  - Cycle 1: req0_ready=1; next cycle wr_en=1, wr_addr=5, wr_src=0, conflict=1.
  - Cycle 2: req1_ready=1; next cycle wr_addr=7, wr_data=0x12345678, wr_src=1.
- Hold both requesters valid for 6 cycles: grants alternate 0,1,0,1,0,1 and wr_en stays high continuously from cycle 2 to cycle 7.
- req1 only, addr=0, data=0xFFFFFFFF: req1_ready=1; next cycle wr_en=0; a following contended cycle grants requester 0.
- hold=1 for 3 cycles with both valid: both ready=0, wr_en=0, conflict=0. On release, the grant goes to the requester not last granted before hold.
- Both requesters target addr=9 in the same cycle, data 0xA and 0xB, PRIO_RESET=1:
  - Write with data 0xB occurs first, then 0xA.
  - The register file ends holding 0xA.
- Assert rst for 1 cycle during continuous contention:
  - Outputs read 0 the next cycle.
  - The first contended grant after reset goes to PRIO_RESET.
